pipeline_exec_ctrl: RTL and testbench

//  Execution controller that drives the global enable of every pipeline register,

---
 rtl/pipeline_exec_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_exec_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_exec_ctrl.sv
// Execution controller for the pipeline's global enable, PC enable included.
// Supports free-run, single-step, pause and a halt-drain sequence. It also
// counts enabled cycles (saturating) and captures the PC at which HALT was
// fetched. Every output comes from a register, so there is no combinational
// path from any input to any output.
module pipeline_exec_ctrl #(
    parameter int PC_WIDTH   = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int HALT_DRAIN = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    input  logic [1:0]           i_cmd,
    output logic                 o_cmd_ready,
    input  logic                 i_halt_fetched,
    input  logic [PC_WIDTH-1:0]  i_pc,
    output logic                 o_enable,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CNT_WIDTH-1:0] o_cycle_count,
    output logic [PC_WIDTH-1:0]  o_halt_pc
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;

    // Drain counter needs at least one bit, even when the drain length is zero.
    localparam int DW = (HALT_DRAIN < 1) ? 1 : $clog2(HALT_DRAIN + 1);

    state_t               state_q, state_d;
    logic [DW-1:0]        drain_q, drain_d;
    logic                 enable_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 ready_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [PC_WIDTH-1:0]  halt_pc_q;
    logic                 cmd_accept;
    logic                 halt_detect;

    // Next-state logic. HALT detection overrides both STOP and the STEP return.
    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        cmd_accept  = i_cmd_valid & ready_q;
        halt_detect = enable_q & i_halt_fetched &
                      ((state_q == S_RUN) || (state_q == S_STEP));
        if (halt_detect) begin
            if (HALT_DRAIN == 0) begin
                state_d = S_HALTED;
            end else begin
                state_d = S_DRAIN;
                drain_d = DW'(HALT_DRAIN);
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_accept) begin
                        if (i_cmd == CMD_RUN) begin
                            state_d = S_RUN;
                        end else if (i_cmd == CMD_STEP) begin
                            state_d = S_STEP;
                        end
                    end
                end
                S_RUN: begin
                    if (cmd_accept && (i_cmd == CMD_STOP)) begin
                        state_d = S_IDLE;
                    end
                end
                S_STEP: begin
                    state_d = S_IDLE;
                end
                S_DRAIN: begin
                    drain_d = drain_q - DW'(1);
                    if (drain_q <= DW'(1)) begin
                        state_d = S_HALTED;
                    end
                end
                S_HALTED: begin
                    state_d = S_HALTED;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, decoded outputs, saturating cycle counter and HALT PC capture.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            drain_q   <= '0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            count_q   <= '0;
            halt_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            enable_q <= (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_DRAIN);
            busy_q   <= (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_DRAIN);
            done_q   <= (state_d == S_HALTED);
            ready_q  <= (state_d == S_IDLE) || (state_d == S_RUN);
            if (enable_q && (count_q != {CNT_WIDTH{1'b1}})) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end
            if (halt_detect) begin
                halt_pc_q <= i_pc;
            end
        end
    end

    assign o_enable      = enable_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_cmd_ready   = ready_q;
    assign o_cycle_count = count_q;
    assign o_halt_pc     = halt_pc_q;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Bench for pipeline_exec_ctrl. It drives two instances from the same stimulus:
// a default one (32-bit counter, drain of 4) and a small one (4-bit counter,
// drain of 0). The bench has a directed vector table, hand-written corner
// sequences, and a randomized run checked against a behavioural model.
module tb_pipeline_exec_ctrl;

    localparam bit [1:0] C_NOP  = 2'b00;
    localparam bit [1:0] C_RUN  = 2'b01;
    localparam bit [1:0] C_STEP = 2'b10;
    localparam bit [1:0] C_STOP = 2'b11;

    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_HALTED = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic        halt = 1'b0;
    logic [31:0] pc = 32'h0;

    logic        rdy_a, en_a, busy_a, done_a;
    logic [31:0] cnt_a, hpc_a;
    logic        rdy_b, en_b, busy_b, done_b;
    logic [3:0]  cnt_b;
    logic [31:0] hpc_b;

    int n_vec = 0;
    int n_err = 0;

    pipeline_exec_ctrl #(.PC_WIDTH(32), .CNT_WIDTH(32), .HALT_DRAIN(4)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(valid), .i_cmd(cmd),
        .o_cmd_ready(rdy_a), .i_halt_fetched(halt), .i_pc(pc),
        .o_enable(en_a), .o_busy(busy_a), .o_done(done_a),
        .o_cycle_count(cnt_a), .o_halt_pc(hpc_a)
    );

    pipeline_exec_ctrl #(.PC_WIDTH(32), .CNT_WIDTH(4), .HALT_DRAIN(0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(valid), .i_cmd(cmd),
        .o_cmd_ready(rdy_b), .i_halt_fetched(halt), .i_pc(pc),
        .o_enable(en_b), .o_busy(busy_b), .o_done(done_b),
        .o_cycle_count(cnt_b), .o_halt_pc(hpc_b)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int              st;
        int              left;
        longint unsigned cnt;
        logic [31:0]     hpc;
    } mdl_t;

    function automatic mdl_t m_reset();
        mdl_t m;
        m.st = M_IDLE; m.left = 0; m.cnt = 0; m.hpc = 32'h0;
        return m;
    endfunction

    function automatic bit m_en(mdl_t m);
        return (m.st == M_RUN) || (m.st == M_STEP) || (m.st == M_DRAIN);
    endfunction

    function automatic bit m_rdy(mdl_t m);
        return (m.st == M_IDLE) || (m.st == M_RUN);
    endfunction

    // One clock edge of the controller, written from the behavioural rules.
    function automatic mdl_t m_step(mdl_t m, bit v, bit [1:0] c, bit h, logic [31:0] p,
                                    int dlen, longint unsigned cmax);
        mdl_t n = m;
        if (m_en(m)) n.cnt = (m.cnt >= cmax) ? cmax : m.cnt + 1;
        if ((m.st == M_RUN || m.st == M_STEP) && h) begin
            n.hpc = p;
            if (dlen == 0) n.st = M_HALTED;
            else begin n.st = M_DRAIN; n.left = dlen; end
            return n;
        end
        if (m.st == M_IDLE && v && c == C_RUN)  n.st = M_RUN;
        if (m.st == M_IDLE && v && c == C_STEP) n.st = M_STEP;
        if (m.st == M_RUN && v && c == C_STOP)  n.st = M_IDLE;
        if (m.st == M_STEP) n.st = M_IDLE;
        if (m.st == M_DRAIN) begin
            n.left = m.left - 1;
            if (n.left == 0) n.st = M_HALTED;
        end
        return n;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit v, input bit [1:0] c, input bit h, input logic [31:0] p);
        @(negedge clk);
        valid = v; cmd = c; halt = h; pc = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid = 1'b0; halt = 1'b0; cmd = C_NOP; pc = 32'h0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        bit          v;
        bit [1:0]    c;
        bit          h;
        logic [31:0] p;
        bit          en;
        bit          busy;
        bit          done;
        bit          rdy;
        logic [31:0] cnt;
        logic [31:0] hpc;
    } vec_t;

    vec_t tbl[11];
    mdl_t ma, mb;

    initial begin
        // rst v cmd h pc | en busy done rdy cnt hpc   (default instance)
        tbl[0]  = '{1'b1, 1'b0, C_NOP,  1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, C_RUN,  1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, C_NOP,  1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 32'd1, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, C_STEP, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b1, 32'd2, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, C_NOP,  1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 32'h40};
        tbl[5]  = '{1'b0, 1'b0, C_NOP,  1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'd4, 32'h40};
        tbl[6]  = '{1'b0, 1'b0, C_NOP,  1'b1, 32'h77, 1'b1, 1'b1, 1'b0, 1'b0, 32'd5, 32'h40};
        tbl[7]  = '{1'b0, 1'b0, C_NOP,  1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 32'd6, 32'h40};
        tbl[8]  = '{1'b0, 1'b0, C_NOP,  1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'd7, 32'h40};
        tbl[9]  = '{1'b0, 1'b1, C_RUN,  1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'd7, 32'h40};
        tbl[10] = '{1'b0, 1'b1, C_STOP, 1'b1, 32'h99, 1'b0, 1'b0, 1'b1, 1'b0, 32'd7, 32'h40};

        // ---- table-driven vectors ----
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; valid = tbl[i].v; cmd = tbl[i].c; halt = tbl[i].h; pc = tbl[i].p;
            @(posedge clk);
            #1;
            $display("tbl[%0d] en=%0b busy=%0b done=%0b rdy=%0b cnt=%0d hpc=%0h",
                     i, en_a, busy_a, done_a, rdy_a, cnt_a, hpc_a);
            chk($sformatf("tbl[%0d].en", i),   64'(en_a),   64'(tbl[i].en));
            chk($sformatf("tbl[%0d].busy", i), 64'(busy_a), 64'(tbl[i].busy));
            chk($sformatf("tbl[%0d].done", i), 64'(done_a), 64'(tbl[i].done));
            chk($sformatf("tbl[%0d].rdy", i),  64'(rdy_a),  64'(tbl[i].rdy));
            chk($sformatf("tbl[%0d].cnt", i),  64'(cnt_a),  64'(tbl[i].cnt));
            chk($sformatf("tbl[%0d].hpc", i),  64'(hpc_a),  64'(tbl[i].hpc));
        end

        // ---- RUN, then STOP after 10 enabled cycles ----
        do_reset();
        cyc(1'b1, C_RUN, 1'b0, 32'h0);
        for (int i = 0; i < 9; i++) cyc(1'b0, C_NOP, 1'b0, 32'h0);
        cyc(1'b1, C_STOP, 1'b0, 32'h0);
        $display("run_stop cnt=%0d en=%0b rdy=%0b", cnt_a, en_a, rdy_a);
        chk("run_stop.cnt",  64'(cnt_a),  64'd10);
        chk("run_stop.en",   64'(en_a),   64'd0);
        chk("run_stop.busy", 64'(busy_a), 64'd0);
        chk("run_stop.rdy",  64'(rdy_a),  64'd1);

        // ---- three STEPs spaced 5 cycles apart ----
        do_reset();
        for (int s = 0; s < 3; s++) begin
            cyc(1'b1, C_STEP, 1'b0, 32'h0);
            chk($sformatf("step%0d.en_hi", s),   64'(en_a),   64'd1);
            chk($sformatf("step%0d.busy_hi", s), 64'(busy_a), 64'd1);
            cyc(1'b0, C_NOP, 1'b0, 32'h0);
            chk($sformatf("step%0d.en_lo", s),   64'(en_a),   64'd0);
            chk($sformatf("step%0d.busy_lo", s), 64'(busy_a), 64'd0);
            for (int k = 0; k < 3; k++) cyc(1'b0, C_NOP, 1'b0, 32'h0);
            $display("step%0d cnt=%0d", s, cnt_a);
        end
        chk("step.cnt", 64'(cnt_a), 64'd3);

        // ---- STOP and HALT in the same cycle while running ----
        do_reset();
        cyc(1'b1, C_RUN, 1'b0, 32'h0);
        cyc(1'b1, C_STOP, 1'b1, 32'h123);
        $display("stop_halt en=%0b rdy=%0b hpc=%0h done_b=%0b", en_a, rdy_a, hpc_a, done_b);
        chk("stop_halt.en",   64'(en_a),   64'd1);
        chk("stop_halt.rdy",  64'(rdy_a),  64'd0);
        chk("stop_halt.hpc",  64'(hpc_a),  64'h123);
        chk("stop_halt.b_done", 64'(done_b), 64'd1);
        chk("stop_halt.b_en",   64'(en_b),   64'd0);

        // ---- STEP landing on HALT, then async reset mid-drain ----
        do_reset();
        cyc(1'b1, C_STEP, 1'b0, 32'h0);
        cyc(1'b0, C_NOP, 1'b1, 32'h200);
        $display("step_halt en=%0b busy=%0b hpc=%0h", en_a, busy_a, hpc_a);
        chk("step_halt.en",  64'(en_a),  64'd1);
        chk("step_halt.rdy", 64'(rdy_a), 64'd0);
        chk("step_halt.hpc", 64'(hpc_a), 64'h200);
        cyc(1'b0, C_NOP, 1'b0, 32'h0);
        chk("pre_reset.cnt", 64'(cnt_a), 64'd2);
        @(negedge clk);
        valid = 1'b0; halt = 1'b0;
        #2 rst = 1'b1;
        #1;
        $display("async_reset en=%0b busy=%0b done=%0b cnt=%0d", en_a, busy_a, done_a, cnt_a);
        chk("async_reset.en",   64'(en_a),   64'd0);
        chk("async_reset.busy", 64'(busy_a), 64'd0);
        chk("async_reset.done", 64'(done_a), 64'd0);
        chk("async_reset.cnt",  64'(cnt_a),  64'd0);
        chk("async_reset.hpc",  64'(hpc_a),  64'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---- counter saturation (4-bit) and zero-length drain ----
        do_reset();
        cyc(1'b1, C_RUN, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) cyc(1'b0, C_NOP, 1'b0, 32'h0);
        $display("saturate cnt_a=%0d cnt_b=%0d", cnt_a, cnt_b);
        chk("sat.cnt_b", 64'(cnt_b), 64'd15);
        chk("sat.cnt_a", 64'(cnt_a), 64'd20);
        cyc(1'b0, C_NOP, 1'b1, 32'h40);
        chk("drain0.b_done", 64'(done_b), 64'd1);
        chk("drain0.b_en",   64'(en_b),   64'd0);
        chk("drain0.b_hpc",  64'(hpc_b),  64'h40);
        chk("drain0.a_busy", 64'(busy_a), 64'd1);

        // ---- randomized run against the reference model ----
        do_reset();
        ma = m_reset();
        mb = m_reset();
        for (int i = 0; i < 600; i++) begin
            bit          r, v, h;
            bit [1:0]    c;
            logic [31:0] p;
            r = ($urandom_range(0, 49) == 0);
            v = ($urandom_range(0, 2) != 0);
            c = 2'($urandom_range(0, 3));
            h = ($urandom_range(0, 19) == 0);
            p = $urandom;
            @(negedge clk);
            rst = r; valid = v; cmd = c; halt = h; pc = p;
            if (r) begin
                ma = m_reset();
                mb = m_reset();
            end else begin
                ma = m_step(ma, v, c, h, p, 4, 64'hFFFF_FFFF);
                mb = m_step(mb, v, c, h, p, 0, 64'd15);
            end
            @(posedge clk);
            #1;
            $display("rnd[%0d] rst=%0b v=%0b c=%0d h=%0b | a en=%0b rdy=%0b done=%0b cnt=%0d | b done=%0b cnt=%0d",
                     i, r, v, c, h, en_a, rdy_a, done_a, cnt_a, done_b, cnt_b);
            chk("rnd.a_en",   64'(en_a),   64'(m_en(ma)));
            chk("rnd.a_busy", 64'(busy_a), 64'(m_en(ma)));
            chk("rnd.a_done", 64'(done_a), 64'(ma.st == M_HALTED));
            chk("rnd.a_rdy",  64'(rdy_a),  64'(m_rdy(ma)));
            chk("rnd.a_cnt",  64'(cnt_a),  ma.cnt);
            chk("rnd.a_hpc",  64'(hpc_a),  64'(ma.hpc));
            chk("rnd.b_en",   64'(en_b),   64'(m_en(mb)));
            chk("rnd.b_done", 64'(done_b), 64'(mb.st == M_HALTED));
            chk("rnd.b_rdy",  64'(rdy_b),  64'(m_rdy(mb)));
            chk("rnd.b_cnt",  64'(cnt_b),  mb.cnt);
            chk("rnd.b_hpc",  64'(hpc_b),  64'(mb.hpc));
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
